// File: rtl/param_channel_sequencer.sv
// Multi-channel output sequencer: walks a rotate/ping-pong/one-shot/thermometer pattern
// across CHANNELS lines, dwelling delay+1 enabled cycles per step; channel decodes from registered state.
module param_channel_sequencer #(
    parameter int CHANNELS = 7,
    parameter int DELAY_W  = 5,
    parameter int STEP_W   = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [DELAY_W-1:0]  delay,
    input  logic [1:0]          mode,
    input  logic                start,
    output logic [CHANNELS-1:0] channel,
    output logic [STEP_W-1:0]   step,
    output logic                done,
    output logic                tick
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [1:0] MODE_ROTATE   = 2'd0;
    localparam logic [1:0] MODE_PINGPONG = 2'd1;
    localparam logic [1:0] MODE_ONESHOT  = 2'd2;
    localparam logic [1:0] MODE_THERMO   = 2'd3;

    localparam logic [STEP_W-1:0] LAST = STEP_W'(CHANNELS - 1);

    logic [STEP_W-1:0]  step_q, step_d;
    dir_t               dir_q, dir_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               tick_q, tick_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= '0;
            dir_q  <= DIR_UP;
            cnt_q  <= '0;
            done_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            step_q <= step_d;
            dir_q  <= dir_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            tick_q <= tick_d;
        end
    end

    always_comb begin
        step_d = step_q;
        dir_d  = dir_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        tick_d = 1'b0;
        if (start) begin
            step_d = '0;
            dir_d  = DIR_UP;
            cnt_d  = '0;
            done_d = 1'b0;
        end else if (enable) begin
            // done only has meaning in one-shot; any other mode drops it
            if (mode != MODE_ONESHOT) begin
                done_d = 1'b0;
            end
            if (cnt_q >= delay) begin
                cnt_d = '0;
                if (!(mode == MODE_ONESHOT && done_q)) begin
                    tick_d = 1'b1;
                    case (mode)
                        MODE_PINGPONG: begin
                            if (dir_q == DIR_UP) begin
                                if (step_q == LAST) begin
                                    dir_d  = DIR_DOWN;
                                    step_d = step_q - 1'b1;
                                end else begin
                                    step_d = step_q + 1'b1;
                                end
                            end else begin
                                if (step_q == '0) begin
                                    dir_d  = DIR_UP;
                                    step_d = step_q + 1'b1;
                                end else begin
                                    step_d = step_q - 1'b1;
                                end
                            end
                        end
                        MODE_ONESHOT: begin
                            if (step_q == LAST) begin
                                done_d = 1'b1;
                            end else begin
                                step_d = step_q + 1'b1;
                            end
                        end
                        default: begin
                            step_d = (step_q == LAST) ? '0 : step_q + 1'b1;
                        end
                    endcase
                end
            end else begin
                cnt_d = cnt_q + DELAY_W'(1);
            end
        end
    end

    always_comb begin
        channel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            case (mode)
                MODE_THERMO:  channel[i] = (STEP_W'(i) <= step_q);
                MODE_ONESHOT: channel[i] = !done_q && (STEP_W'(i) == step_q);
                default:      channel[i] = (STEP_W'(i) == step_q);
            endcase
        end
    end

    assign step = step_q;
    assign done = done_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_param_channel_sequencer.sv
// Scoreboard bench for param_channel_sequencer (CHANNELS=7, DELAY_W=5): a behavioural model
// pushes the expected post-edge outputs each cycle; they are popped and compared after the edge.
module tb_param_channel_sequencer;

    localparam int N = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [4:0] delay;
    logic [1:0] mode;
    logic       start;
    logic [6:0] channel;
    logic [2:0] step;
    logic       done;
    logic       tick;

    param_channel_sequencer #(.CHANNELS(N), .DELAY_W(5)) dut (
        .clk(clk), .rst(rst), .enable(enable), .delay(delay), .mode(mode),
        .start(start), .channel(channel), .step(step), .done(done), .tick(tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int st;
        int dn;
        int tk;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int failures = 0;

    // model state
    int m_step = 0, m_dir = 0, m_cnt = 0, m_done = 0, m_tick = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int decode(input int md, input int st, input int dn);
        int r;
        r = 0;
        if (md == 3) begin
            for (int i = 0; i <= st; i++) r = r + (1 << i);
        end else if (md == 2 && dn != 0) begin
            r = 0;
        end else begin
            r = 1 << st;
        end
        return r;
    endfunction

    task automatic model_next();
        if (rst) begin
            m_step = 0; m_dir = 0; m_cnt = 0; m_done = 0; m_tick = 0;
        end else if (start) begin
            m_step = 0; m_dir = 0; m_cnt = 0; m_done = 0; m_tick = 0;
        end else if (!enable) begin
            m_tick = 0;
        end else begin
            int was_done;
            was_done = m_done;
            m_tick = 0;
            if (mode != 2) m_done = 0;
            if (m_cnt >= int'(delay)) begin
                m_cnt = 0;
                if (!(mode == 2 && was_done != 0)) begin
                    m_tick = 1;
                    if (mode == 1) begin
                        if (m_dir == 0) begin
                            if (m_step == N - 1) begin m_dir = 1; m_step = N - 2; end
                            else m_step = m_step + 1;
                        end else begin
                            if (m_step == 0) begin m_dir = 0; m_step = 1; end
                            else m_step = m_step - 1;
                        end
                    end else if (mode == 2) begin
                        if (m_step == N - 1) m_done = 1;
                        else m_step = m_step + 1;
                    end else begin
                        m_step = (m_step == N - 1) ? 0 : m_step + 1;
                    end
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    // mode for the decode is the one still applied after the edge (inputs unchanged until #1)
    task automatic cycle(input string tag);
        exp_t e;
        exp_t g;
        model_next();
        e.ch = decode(int'(mode), m_step, m_done);
        e.st = m_step;
        e.dn = m_done;
        e.tk = m_tick;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        g = sb_q.pop_front();
        check({tag, "_ch"}, int'(channel), g.ch);
        check({tag, "_step"}, int'(step), g.st);
        check({tag, "_done"}, int'(done), g.dn);
        check({tag, "_tick"}, int'(tick), g.tk);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    task automatic pulse_start(input string tag);
        start = 1'b1;
        cycle(tag);
        start = 1'b0;
    endtask

    initial begin
        int rot_tab[7];
        int dwell;
        int budget;

        rst = 1'b1; enable = 1'b1; delay = 5'd0; mode = 2'd0; start = 1'b0;

        // 1: reset, rotate every cycle
        run("rst", 2);
        check("rst_channel_one", int'(channel), 1);
        check("rst_tick_zero", int'(tick), 0);
        rst = 1'b0;
        rot_tab[0] = 'h02; rot_tab[1] = 'h04; rot_tab[2] = 'h08; rot_tab[3] = 'h10;
        rot_tab[4] = 'h20; rot_tab[5] = 'h40; rot_tab[6] = 'h01;
        for (int i = 0; i < 7; i++) begin
            cycle("rot");
            check("rot_table", int'(channel), rot_tab[i]);
        end

        // 2: rotate delay=3 with a 5-cycle pause mid-dwell
        delay = 5'd3;
        pulse_start("t2_start");
        run("t2", 8);
        budget = 0;
        while (tick !== 1'b1 && budget < 20) begin cycle("t2_sync"); budget++; end
        check("t2_sync_found", int'(tick), 1);
        dwell = 1;
        run("t2_en", 2); dwell += 2;
        enable = 1'b0;
        run("t2_pause", 5); dwell += 5;
        enable = 1'b1;
        budget = 0;
        cycle("t2_resume");
        while (tick !== 1'b1 && budget < 20) begin dwell++; cycle("t2_resume"); budget++; end
        check("t2_paused_dwell", dwell, 9);
        run("t2_after", 8);

        // 3: ping-pong delay=0
        mode = 2'd1; delay = 5'd0;
        pulse_start("t3_start");
        run("t3", 16);

        // 4: one-shot delay=1, then 20 cycles done, then restart
        mode = 2'd2; delay = 5'd1;
        pulse_start("t4_start");
        run("t4_walk", 14);
        check("t4_done_set", int'(done), 1);
        check("t4_channel_off", int'(channel), 0);
        run("t4_hold", 20);
        pulse_start("t4_restart");
        check("t4_restart_ch", int'(channel), 1);
        check("t4_restart_done", int'(done), 0);
        run("t4_again", 4);

        // 5: thermometer, switch to rotate at step 4
        mode = 2'd3; delay = 5'd0;
        pulse_start("t5_start");
        run("t5", 4);
        check("t5_therm_step4", int'(channel), 'h1F);
        mode = 2'd0;
        #1;
        check("t5_switch_imm", int'(channel), 'h10);
        run("t5_rot", 4);
        mode = 2'd3;
        run("t5_therm", 8);

        // 6: lower delay below the count, then rst+start together mid-step
        mode = 2'd0; delay = 5'd10;
        pulse_start("t6_start");
        budget = 0;
        while (m_cnt != 5 && budget < 30) begin cycle("t6_count"); budget++; end
        check("t6_count_reached", m_cnt, 5);
        delay = 5'd2;
        cycle("t6_lower");
        check("t6_forced_tick", int'(tick), 1);
        delay = 5'd6;
        run("t6_mid", 3);
        rst = 1'b1; start = 1'b1;
        cycle("t6_rst");
        check("t6_rst_step", int'(step), 0);
        check("t6_rst_ch", int'(channel), 1);
        check("t6_rst_tick", int'(tick), 0);
        check("t6_rst_done", int'(done), 0);
        rst = 1'b0; start = 1'b0;

        // random mix of all inputs, checked against the model
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 99) == 0);
            start  = ($urandom_range(0, 49) == 0);
            enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) delay = 5'($urandom_range(0, 4));
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/param_channel_sequencer.md
Name: param_channel_sequencer

Overview:
Multi-channel output sequencer: steps an active pattern across CHANNELS output lines, dwelling (delay+1) enabled cycles on each step. Generalises the fixed 7-channel, 5-bit-delay sequencer. Adds parametrised channel count and delay width, four run modes (rotate, ping-pong, one-shot, thermometer), a restart input, a done flag and a step strobe. Sits behind the io_in/io_out pin wrapper; its outputs drive channel pins directly.

Parameters:
CHANNELS, 7, number of output channels; legal range 2..32.
DELAY_W, 5, width of the dwell-delay input.
STEP_W, $clog2(CHANNELS), width of the step index (derived; do not override).

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
enable  in  1  high = prescaler runs; low = freeze all sequencing state.
delay  in  DELAY_W  dwell length; each step lasts delay+1 enabled cycles.
mode  in  2  0 rotate, 1 ping-pong, 2 one-shot, 3 thermometer.
start  in  1  one-cycle restart pulse.
channel  out  CHANNELS  pattern output.
step  out  STEP_W  current step index.
done  out  1  one-shot complete (mode 2 only).
tick  out  1  one-cycle strobe, high in the first cycle a new step is visible.

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high on rst.
- State: step, dir (up/down), prescale counter (DELAY_W bits), done, tick.
- Reset values: step=0, dir=up, counter=0, done=0, tick=0. Hence channel=1 (bit 0 set).
- Priority per edge: rst > start > normal advance.
- start: step=0, dir=up, counter=0, done=0, tick=0. Acts in any mode, independent of enable.
- Prescaler (enable=1): if counter >= delay, then counter<=0 and advance. Otherwise counter<=counter+1.
  - Comparison is >=. Lowering delay below the current count forces an advance on the next edge.
  - delay=0 advances every enabled cycle.
- enable=0: counter, step, dir and done all hold; tick<=0.
- tick is registered: 1 on the edge that performs an advance, else 0.
  - No tick when one-shot is already done.
  - No tick on start or rst.
- Advance rules by mode:
  - 0 rotate: step+1; CHANNELS-1 wraps to 0. dir is ignored and unchanged.
  - 1 ping-pong: if dir=up and step=CHANNELS-1, dir<=down and step-1. If dir=down and step=0, dir<=up and step+1. Otherwise step±1 per dir.
    - Each endpoint is visited for exactly one dwell per bounce.
    - Sequence: 0..N-1, N-2..1, 0, 1...
  - 2 one-shot: step+1 until CHANNELS-1. The advance out of CHANNELS-1 sets done=1 and leaves step at CHANNELS-1. Once done, there are no further advances or ticks until start or rst.
  - 3 thermometer: step advances exactly as in rotate.
- channel is a combinational decode of registered state:
  - modes 0, 1: one-hot, bit[step] set.
  - mode 2: one-hot bit[step] while done=0; all zeros while done=1.
  - mode 3: bits [step:0] set, i.e. (2<<step)-1 truncated to CHANNELS.
- Mode change mid-run:
  - step, counter and dir are retained; the new decode applies immediately.
  - Entering mode 1 with a stale dir is corrected at the next endpoint.
  - Leaving mode 2 clears done on the next edge; sequencing resumes from the current step.
- Widths:
  - step never exceeds CHANNELS-1 for non-power-of-two CHANNELS.
  - counter never wraps past the 2^DELAY_W-1 maximum, because the delay compare bounds it.
- rst asserted mid-dwell or mid-one-shot returns to the reset state on that edge, regardless of enable, start or mode.

Test Plan:
1. CHANNELS=7, DELAY_W=5; rst 2 cycles, mode=0, delay=0, enable=1 -> channel 0x01,0x02,0x04..0x40,0x01 on successive cycles; tick=1 every cycle after the first advance.
2. mode=0, delay=3; drop enable for 5 cycles mid-dwell -> every other step lasts exactly 4 cycles; the paused step lasts 9; no tick during the pause.
3. mode=1, delay=0 -> step 0,1,..,6,5,..,1,0,1; 0x40 and 0x01 each held exactly one cycle per bounce.
4. mode=2, delay=1 -> steps 0..6 at 2 cycles each, then channel=0x00 and done=1, held 20 cycles with no tick; start pulse -> next cycle channel=0x01, done=0, step dwell restarts at a full 2 cycles.
5. mode=3, delay=0 -> 0x01,0x03,0x07,0x0F,0x1F,0x3F,0x7F,0x01; switch to mode=0 at step 4 -> channel becomes 0x10 immediately.
6. delay=10 with counter=5, then delay set to 2 -> advance on the next edge. Assert rst and start together mid-step -> reset state: step=0, channel=0x01, tick=0, done=0.
